// File: rtl/jtag_debug_ocimem_responder_if.sv
// Bundles the JTAG debug-slave command/response signals and the CPU-side
// Avalon-MM slave port of the OCI debug RAM responder.
//   slave  : the responder (consumes strobes/jdo and the Avalon request,
//            drives MonDReg/monitor_* and the Avalon response)
//   master : the environment (debug slave + CPU)
interface jtag_debug_ocimem_responder_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic              avs_waitrequest;

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        output MonDReg, monitor_ready, monitor_error,
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_readdatavalid, avs_waitrequest
    );

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        input  MonDReg, monitor_ready, monitor_error,
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_readdatavalid, avs_waitrequest
    );
endinterface

// File: rtl/jtag_debug_ocimem_responder.sv
// Target-side responder for the JTAG debug slave's OCI-memory commands.
// Executes JTAG word reads/writes on a single-port 32-bit debug RAM that the
// CPU monitor also reaches through an Avalon-MM slave port.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   bus   - slave modport: jdo + command strobes in, MonDReg/monitor_ready/
//           monitor_error out; Avalon-MM avs_* request in, response out
module jtag_debug_ocimem_responder #(
    parameter int ADDR_W = 8
) (
    input logic clk,
    input logic reset,
    jtag_debug_ocimem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, PEND} state_t;

    state_t            state;
    logic              pend_wr;
    logic [31:0]       pend_data;
    logic [ADDR_W-1:0] mon_a_reg;
    logic              starve;
    logic              jtag_done_p1;
    logic              jtag_rd_p1;
    logic [31:0]       rd_q;
    logic [31:0]       mon_d_reg;
    logic              mon_ready;
    logic              mon_error;
    logic              rd_vld_p1;
    logic [31:0]       mem [DEPTH];

    logic              cpu_req;
    logic              pending;
    logic              jtag_grant;
    logic              cpu_grant;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic              any_strobe;
    logic              unused_jdo;

    assign unused_jdo = ^{bus.jdo[36:35], bus.jdo[2:0]};

    // The CPU wins unless JTAG has already been passed over once (starve).
    assign cpu_req    = bus.avs_read | bus.avs_write;
    assign pending    = (state == PEND);
    assign jtag_grant = pending && (!cpu_req || starve);
    assign cpu_grant  = cpu_req && !jtag_grant;

    assign ram_addr  = jtag_grant ? mon_a_reg : bus.avs_address;
    assign ram_we    = (jtag_grant && pend_wr) || (cpu_grant && bus.avs_write);
    assign ram_re    = (jtag_grant && !pend_wr) || (cpu_grant && bus.avs_read);
    assign ram_wdata = jtag_grant ? pend_data : bus.avs_writedata;
    assign ram_be    = jtag_grant ? 4'hF : bus.avs_byteenable;

    assign any_strobe = bus.take_action_ocimem_a | bus.take_no_action_ocimem_a |
                        bus.take_action_ocimem_b;

    assign bus.avs_waitrequest   = jtag_grant && cpu_req;
    assign bus.avs_readdata      = rd_q;
    assign bus.avs_readdatavalid = rd_vld_p1;
    assign bus.MonDReg           = mon_d_reg;
    assign bus.monitor_ready     = mon_ready;
    assign bus.monitor_error     = mon_error;

    // Stage p0: single-port RAM write with byte lanes
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

    // Write payload captured when a write command is accepted
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.take_action_ocimem_b) pend_data <= bus.jdo[34:3];
    end

    // Stage p0 -> p1: registered RAM read port shared by CPU and JTAG
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
        end else if (ram_re) begin
            rd_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pend_wr      <= 1'b0;
            mon_a_reg    <= '0;
            starve       <= 1'b0;
            jtag_done_p1 <= 1'b0;
            jtag_rd_p1   <= 1'b0;
            mon_d_reg    <= '0;
            mon_ready    <= 1'b1;
            mon_error    <= 1'b0;
            rd_vld_p1    <= 1'b0;
        end else begin
            rd_vld_p1    <= cpu_grant && bus.avs_read;
            jtag_done_p1 <= jtag_grant;
            jtag_rd_p1   <= jtag_grant && !pend_wr;

            // Stage p1: JTAG completion, read data lands in MonDReg
            if (jtag_done_p1) begin
                mon_ready <= 1'b1;
                if (jtag_rd_p1) mon_d_reg <= rd_q;
            end

            if (jtag_grant)
                starve <= 1'b0;
            else if (pending && cpu_req)
                starve <= 1'b1;

            if (state == PEND) begin
                if (any_strobe) mon_error <= 1'b1;
                if (jtag_grant) begin
                    state     <= IDLE;
                    mon_a_reg <= mon_a_reg + ADDR_W'(1);
                end
            end else begin
                // Priority b > no_action_a > action_a; losers flag an overrun.
                if (bus.take_action_ocimem_b) begin
                    state     <= PEND;
                    pend_wr   <= 1'b1;
                    mon_ready <= 1'b0;
                    if (bus.take_action_ocimem_a || bus.take_no_action_ocimem_a)
                        mon_error <= 1'b1;
                end else if (bus.take_no_action_ocimem_a) begin
                    state     <= PEND;
                    pend_wr   <= 1'b0;
                    mon_ready <= 1'b0;
                    if (bus.take_action_ocimem_a) mon_error <= 1'b1;
                end else if (bus.take_action_ocimem_a) begin
                    mon_a_reg <= bus.jdo[17 +: ADDR_W];
                    if (bus.jdo[37]) mon_error <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtag_debug_ocimem_responder.sv
module tb_jtag_debug_ocimem_responder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    jtag_debug_ocimem_responder_if #(.ADDR_W(8)) bus ();

    jtag_debug_ocimem_responder #(.ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        int n;
        bus.avs_address    = addr;
        bus.avs_writedata  = data;
        bus.avs_byteenable = be;
        bus.avs_write      = 1'b1;
        #1;
        n = 0;
        while (bus.avs_waitrequest && n < 10) begin
            tick();
            n++;
        end
        tick();
        bus.avs_write = 1'b0;
    endtask

    task automatic strobe_a(input logic [7:0] addr, input logic clr);
        logic [37:0] j;
        j = '0;
        j[37] = clr;
        j[24:17] = addr;
        bus.jdo = j;
        bus.take_action_ocimem_a = 1'b1;
        tick();
        bus.take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_n();
        bus.take_no_action_ocimem_a = 1'b1;
        tick();
        bus.take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        j[34:3] = data;
        bus.jdo = j;
        bus.take_action_ocimem_b = 1'b1;
        tick();
        bus.take_action_ocimem_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.MonDReg !== 32'h0) begin n_fail++; $display("FAIL reset_mondreg got=%h exp=%h", bus.MonDReg, 32'h0); end
        n_checks++;
        if (bus.monitor_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.monitor_ready); end
        n_checks++;
        if (bus.monitor_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", bus.monitor_error); end
        n_checks++;
        if (bus.avs_readdata !== 32'h0 || bus.avs_readdatavalid !== 1'b0 || bus.avs_waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_avs got rd=%h rdv=%b wr=%b exp 0/0/0", bus.avs_readdata, bus.avs_readdatavalid, bus.avs_waitrequest);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_addr_read();
        cpu_write(8'h10, 32'hDEADBEEF, 4'hF);
        strobe_a(8'h10, 1'b0);
        n_checks++;
        if (bus.monitor_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready_idle got=%b exp=1", bus.monitor_ready); end
        strobe_n();
        n_checks++;
        if (bus.monitor_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_c1 got=%b exp=0", bus.monitor_ready); end
        tick();
        n_checks++;
        if (bus.monitor_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_c2 got=%b exp=0", bus.monitor_ready); end
        tick();
        n_checks++;
        if (bus.monitor_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready_done got=%b exp=1", bus.monitor_ready); end
        n_checks++;
        if (bus.MonDReg !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=%h", bus.MonDReg, 32'hDEADBEEF); end
        n_checks++;
        if (dut.mon_a_reg !== 8'h11) begin n_fail++; $display("FAIL rd_addr_inc got=%h exp=%h", dut.mon_a_reg, 8'h11); end
    endtask

    task automatic test_write_wrap();
        strobe_a(8'hFF, 1'b0);
        strobe_b(32'h12345678);
        n_checks++;
        if (bus.monitor_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_busy got=%b exp=0", bus.monitor_ready); end
        tick();
        tick();
        n_checks++;
        if (bus.monitor_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_done got=%b exp=1", bus.monitor_ready); end
        n_checks++;
        if (dut.mon_a_reg !== 8'h00) begin n_fail++; $display("FAIL wr_addr_wrap got=%h exp=%h", dut.mon_a_reg, 8'h00); end
        bus.avs_address = 8'hFF;
        bus.avs_read = 1'b1;
        n_checks++;
        if (bus.avs_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL wr_rdv_before got=%b exp=0", bus.avs_readdatavalid); end
        tick();
        bus.avs_read = 1'b0;
        n_checks++;
        if (bus.avs_readdatavalid !== 1'b1 || bus.avs_readdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wr_cpu_read got rdv=%b data=%h exp 1/%h", bus.avs_readdatavalid, bus.avs_readdata, 32'h12345678);
        end
        tick();
        n_checks++;
        if (bus.avs_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL wr_rdv_after got=%b exp=0", bus.avs_readdatavalid); end
    endtask

    task automatic test_contention();
        cpu_write(8'h20, 32'hCAFEF00D, 4'hF);
        cpu_write(8'h30, 32'h11111111, 4'hF);
        strobe_a(8'h20, 1'b0);
        bus.avs_address = 8'h30;
        bus.avs_read = 1'b1;
        strobe_n();
        n_checks++;
        if (bus.avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL ct_wait_c1 got=%b exp=0", bus.avs_waitrequest); end
        tick();
        n_checks++;
        if (bus.avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL ct_wait_c2 got=%b exp=1", bus.avs_waitrequest); end
        n_checks++;
        if (bus.avs_readdatavalid !== 1'b1 || bus.avs_readdata !== 32'h11111111) begin
            n_fail++;
            $display("FAIL ct_cpu_c1 got rdv=%b data=%h exp 1/%h", bus.avs_readdatavalid, bus.avs_readdata, 32'h11111111);
        end
        tick();
        n_checks++;
        if (bus.avs_waitrequest !== 1'b0 || bus.avs_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL ct_c3 got wait=%b rdv=%b exp 0/0", bus.avs_waitrequest, bus.avs_readdatavalid);
        end
        tick();
        n_checks++;
        if (bus.MonDReg !== 32'hCAFEF00D || bus.monitor_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ct_jtag got data=%h ready=%b exp %h/1", bus.MonDReg, bus.monitor_ready, 32'hCAFEF00D);
        end
        n_checks++;
        if (bus.avs_readdatavalid !== 1'b1 || bus.avs_readdata !== 32'h11111111) begin
            n_fail++;
            $display("FAIL ct_cpu_resume got rdv=%b data=%h exp 1/%h", bus.avs_readdatavalid, bus.avs_readdata, 32'h11111111);
        end
        bus.avs_read = 1'b0;
        tick();
    endtask

    task automatic test_overrun();
        strobe_a(8'h40, 1'b0);
        n_checks++;
        if (bus.monitor_error !== 1'b0) begin n_fail++; $display("FAIL ov_error_pre got=%b exp=0", bus.monitor_error); end
        strobe_n();
        strobe_n();
        tick();
        n_checks++;
        if (bus.monitor_error !== 1'b1) begin n_fail++; $display("FAIL ov_error_set got=%b exp=1", bus.monitor_error); end
        n_checks++;
        if (dut.mon_a_reg !== 8'h41 || bus.monitor_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ov_single_read got addr=%h ready=%b exp %h/1", dut.mon_a_reg, bus.monitor_ready, 8'h41);
        end
        strobe_a(8'h00, 1'b1);
        n_checks++;
        if (bus.monitor_error !== 1'b0) begin n_fail++; $display("FAIL ov_error_clr got=%b exp=0", bus.monitor_error); end
    endtask

    task automatic test_byteenable();
        cpu_write(8'h50, 32'h00000000, 4'hF);
        cpu_write(8'h50, 32'hAABBCCDD, 4'b0101);
        strobe_a(8'h50, 1'b0);
        strobe_n();
        tick();
        tick();
        n_checks++;
        if (bus.MonDReg !== 32'h00BB00DD) begin n_fail++; $display("FAIL be_data got=%h exp=%h", bus.MonDReg, 32'h00BB00DD); end
    endtask

    task automatic test_async_reset();
        strobe_a(8'h60, 1'b0);
        bus.avs_address = 8'h10;
        bus.avs_read = 1'b1;
        strobe_n();
        strobe_n();
        n_checks++;
        if (bus.avs_waitrequest !== 1'b1 || bus.monitor_error !== 1'b1 || bus.monitor_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_pre got wait=%b err=%b ready=%b exp 1/1/0", bus.avs_waitrequest, bus.monitor_error, bus.monitor_ready);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.monitor_ready !== 1'b1 || bus.monitor_error !== 1'b0 || bus.MonDReg !== 32'h0) begin
            n_fail++;
            $display("FAIL ar_monitor got ready=%b err=%b data=%h exp 1/0/0", bus.monitor_ready, bus.monitor_error, bus.MonDReg);
        end
        n_checks++;
        if (bus.avs_waitrequest !== 1'b0 || bus.avs_readdatavalid !== 1'b0 || bus.avs_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL ar_avs got wait=%b rdv=%b data=%h exp 0/0/0", bus.avs_waitrequest, bus.avs_readdatavalid, bus.avs_readdata);
        end
        n_checks++;
        if (dut.mon_a_reg !== 8'h00) begin n_fail++; $display("FAIL ar_addr got=%h exp=%h", dut.mon_a_reg, 8'h00); end
        bus.avs_read = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        cpu_write(8'h00, 32'h0BADF00D, 4'hF);
        strobe_n();
        tick();
        tick();
        n_checks++;
        if (bus.MonDReg !== 32'h0BADF00D || bus.monitor_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_read0 got data=%h ready=%b exp %h/1", bus.MonDReg, bus.monitor_ready, 32'h0BADF00D);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.jdo                     = '0;
        bus.take_action_ocimem_a    = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b    = 1'b0;
        bus.avs_address             = '0;
        bus.avs_read                = 1'b0;
        bus.avs_write               = 1'b0;
        bus.avs_writedata           = '0;
        bus.avs_byteenable          = 4'hF;

        test_reset();
        test_addr_read();
        test_write_wrap();
        test_contention();
        test_overrun();
        test_byteenable();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jtag_debug_ocimem_responder.md
Name: jtag_debug_ocimem_responder

Overview:
- Target-side responder to the JTAG debug slave's OCI-memory command strobes, in the CPU system clock domain.
- Decodes the take_action_ocimem_a, take_action_ocimem_b and take_no_action_ocimem_a strobes, together with jdo.
- Executes word reads and writes on a single-port debug RAM that the CPU's monitor code shares through an Avalon-MM slave port.
- Returns MonDReg, monitor_ready and monitor_error to the debug slave.

Parameters:
- ADDR_W, 8, RAM word-address width. DEPTH = 2**ADDR_W words of 32 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- jdo  in  38  command/data word from debug slave
- take_action_ocimem_a  in  1  address-load strobe, 1 cycle
- take_no_action_ocimem_a  in  1  read strobe, 1 cycle
- take_action_ocimem_b  in  1  write strobe, 1 cycle
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  no JTAG operation outstanding
- monitor_error  out  1  sticky command-overrun flag
- avs_address  in  ADDR_W  CPU word address
- avs_read  in  1  CPU read request
- avs_write  in  1  CPU write request
- avs_writedata  in  32  CPU write data
- avs_byteenable  in  4  CPU byte lanes
- avs_readdata  out  32  CPU read data
- avs_readdatavalid  out  1  CPU read data valid
- avs_waitrequest  out  1  CPU request stalled (combinational)

Behaviour:
- Reset values: MonDReg=0, MonAReg=0 (internal address register), monitor_ready=1, monitor_error=0, avs_readdata=0, avs_readdatavalid=0, avs_waitrequest=0, pending=0, starve=0. RAM contents are not reset.
- Command decode (registered into a one-deep pending slot with state IDLE/PEND):
  - take_action_ocimem_a: MonAReg<=jdo[17+:ADDR_W]. If jdo[37]=1, monitor_error<=0. No RAM access and no change to monitor_ready. Executes in IDLE only.
  - take_no_action_ocimem_a: pending read at MonAReg. State IDLE->PEND, monitor_ready<=0 on the next edge.
  - take_action_ocimem_b: pending write of jdo[34:3] (all 4 bytes) at MonAReg. State IDLE->PEND, monitor_ready<=0.
- Any strobe arriving in PEND is dropped and sets monitor_error<=1; the pending operation is unaffected.
- Simultaneous strobes: priority is b > no_action_a > action_a. Losing strobes are dropped and set monitor_error.
- Arbitration, evaluated each cycle the RAM is requested:
  - If no JTAG op is pending, the CPU is granted.
  - If pending with no CPU request, JTAG is granted.
  - If both request and starve=0, the CPU is granted and starve<=1.
  - If both request and starve=1, JTAG is granted, avs_waitrequest=1 that cycle, and starve<=0.
  - A JTAG op therefore waits at most 2 grant cycles.
- JTAG grant in cycle G: RAM access at MonAReg; MonAReg<=MonAReg+1 with wrap modulo DEPTH (0xFF->0x00); PEND->IDLE.
  - Read: MonDReg<=RAM q at G+1 and monitor_ready<=1 at G+1.
  - Write: RAM written at G; monitor_ready<=1 at G+1.
- CPU read granted at cycle C: avs_readdata valid and avs_readdatavalid=1 at C+1, for one cycle. CPU writes honour avs_byteenable.
- Read-during-write to the same address in one cycle cannot occur (single port). A JTAG read following a CPU write returns the new data.
- Reset asserted mid-operation: the pending op is discarded and all outputs go to reset values immediately; MonAReg=0.

Test Plan:
- Addr load plus read: RAM[0x10]=0xDEADBEEF, action_a with jdo[24:17]=0x10, then no_action_a. monitor_ready=0 for 2 cycles, then MonDReg=0xDEADBEEF, and MonAReg=0x11.
- Write then wrap: load 0xFF, ocimem_b with jdo[34:3]=0x12345678. CPU read at 0xFF returns 0x12345678 with readdatavalid exactly 1 cycle after the request; MonAReg=0x00.
- Contention: CPU asserts avs_read continuously while a JTAG read is pending. The CPU gets cycle 1, then waitrequest=1 on cycle 2 when JTAG is granted. MonDReg is correct, and CPU reads resume the following cycle.
- Overrun: a second no_action_a one cycle after the first gives monitor_error=1 and only one read executed. action_a with jdo[37]=1 gives monitor_error=0.
- Byte enables: CPU writes 0xAABBCCDD with byteenable=4'b0101 over 0x00000000; JTAG read returns 0x00BB00DD.
- Async reset asserted while in PEND: all outputs return to reset values without a clk edge; a subsequent read at address 0 works.
